// File: rtl/affine_sb_scheduler.sv
// Walks an affine CU in raster order of 4x4 (2**SB_SIZE_LOG2) sub-blocks, issuing one start
// per sub-block and waiting for a done rising edge. Optional WAIT watchdog: `SB_TIMEOUT_EN.
module affine_sb_scheduler #(
  parameter int unsigned SB_SIZE_LOG2   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cu_start,
  input  logic [2:0]  cu_w_log2,
  input  logic [2:0]  cu_h_log2,
  input  logic [15:0] cu_cpmv_0,
  input  logic [15:0] cu_cpmv_1,
  input  logic        sb_done,
  output logic        cu_ready,
  output logic        sb_start,
  output logic [7:0]  sb_coord_x,
  output logic [7:0]  sb_coord_y,
  output logic [15:0] sb_cpmv_0,
  output logic [15:0] sb_cpmv_1,
  output logic [9:0]  sb_index,
  output logic        cu_done,
  output logic        cu_error
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  localparam logic [2:0] SbLog2 = 3'(SB_SIZE_LOG2);

  state_e      state_q, state_d;
  logic [2:0]  w_log2_q, h_log2_q;
  logic [15:0] cpmv0_q, cpmv1_q;
  logic [4:0]  col_q, col_d, row_q, row_d;
  logic [9:0]  index_q, index_d;
  logic [4:0]  last_col, last_row;
  logic        done_q, done_rise, accept, last_sb, timeout;

  // Sizes below the 8-sample minimum are raised to 3; the 3-bit field already caps at 7.
  function automatic logic [2:0] clamp_log2(input logic [2:0] v);
    return (v < 3'd3) ? 3'd3 : v;
  endfunction

  assign accept    = (state_q == StIdle) && cu_start;
  assign done_rise = sb_done & ~done_q;
  assign last_col  = 5'((6'd1 << (w_log2_q - SbLog2)) - 6'd1);
  assign last_row  = 5'((6'd1 << (h_log2_q - SbLog2)) - 6'd1);
  assign last_sb   = (col_q == last_col) && (row_q == last_row);

`ifdef SB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] wait_cnt_q;
  logic            error_q, error_d;

  // The counter holds the number of completed WAIT cycles, so the limit fires on the Nth one.
  assign timeout = (state_q == StWait) && (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    error_d = error_q;
    if (accept) begin
      error_d = 1'b0;
    end else if (timeout && !done_rise) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= error_d;
      if (state_q == StIssue) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign cu_error = error_q;
`else
  assign timeout  = 1'b0;
  assign cu_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        if (cu_start) begin
          state_d = StIssue;
          col_d   = '0;
          row_d   = '0;
          index_d = '0;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // A done edge coinciding with the watchdog limit completes normally.
        if (done_rise) begin
          if (last_sb) begin
            state_d = StFinish;
          end else begin
            state_d = StIssue;
            index_d = index_q + 10'd1;
            if (col_q == last_col) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end else if (timeout) begin
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      w_log2_q <= '0;
      h_log2_q <= '0;
      cpmv0_q  <= '0;
      cpmv1_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      index_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      index_q <= index_d;
      done_q  <= sb_done;
      if (accept) begin
        w_log2_q <= clamp_log2(cu_w_log2);
        h_log2_q <= clamp_log2(cu_h_log2);
        cpmv0_q  <= cu_cpmv_0;
        cpmv1_q  <= cu_cpmv_1;
      end
    end
  end

  assign cu_ready   = (state_q == StIdle);
  assign sb_start   = (state_q == StIssue);
  assign cu_done    = (state_q == StFinish);
  assign sb_coord_x = {3'b000, col_q} << SB_SIZE_LOG2;
  assign sb_coord_y = {3'b000, row_q} << SB_SIZE_LOG2;
  assign sb_cpmv_0  = cpmv0_q;
  assign sb_cpmv_1  = cpmv1_q;
  assign sb_index   = index_q;

endmodule
